// File: rtl/rf_wport_arbiter_if.sv
// Purpose: bundles the WB, multi-cycle, issue/ID and register-file write signals of rf_wport_arbiter.
// Latency: n/a (wiring only).
// Backpressure: mc_ready is the only backpressure signal; the WB and issue inputs cannot be stalled.
// Ports: wb_valid/wb_reg/wb_data      - WB stage write request
//        mc_valid/mc_ready/mc_reg/mc_data - multi-cycle result handshake
//        iss_valid/iss_reg             - multi-cycle issue, marks destination busy
//        rs/rt/hazard                  - ID RAW hazard lookup
//        stall_req                     - request for a WB bubble
//        rf_we/rf_wreg/rf_wdata        - registered register-file write port
// Modports: master drives requests (pipeline side), slave is the arbiter.
interface rf_wport_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_reg;
  logic [31:0] mc_data;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hazard;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;

  modport master (
    output wb_valid, wb_reg, wb_data,
    output mc_valid, mc_reg, mc_data,
    output iss_valid, iss_reg, rs, rt,
    input  mc_ready, hazard, stall_req,
    input  rf_we, rf_wreg, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  mc_valid, mc_reg, mc_data,
    input  iss_valid, iss_reg, rs, rt,
    output mc_ready, hazard, stall_req,
    output rf_we, rf_wreg, rf_wdata
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Purpose: shares the single register-file write port between WB (priority) and a buffered multi-cycle unit; tracks busy destinations.
// Latency: WB write appears one cycle after request; multi-cycle result no earlier than two cycles after push (no bypass).
// Backpressure: mc_ready drops when the result FIFO is full (no pass-through on pop); stall_req asks for a WB bubble after STARVE_MAX denials.
// Ports: clk        - rising-edge clock
//        rst        - asynchronous active-low reset
//        bus(slave) - WB / multi-cycle / issue / ID / register-file signals, see rf_wport_arbiter_if
module rf_wport_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_wport_arbiter_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [SW-1:0] ST_ONE   = 1;
  localparam logic [SW-1:0] ST_MAX   = STARVE_MAX[SW-1:0];

  // Result FIFO storage; contents need no reset because count gates every read.
  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [SW-1:0] starve_cnt;
  logic          stall_q;
  logic [31:0]   busy, busy_nxt;

  logic          we_q;
  logic [4:0]    wreg_q;
  logic [31:0]   wdata_q;

  logic          wb_go, fifo_empty, fifo_go, push;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  // A WB write to r0 is an idle slot the FIFO may use.
  assign wb_go      = bus.wb_valid & (bus.wb_reg != 5'd0);
  assign fifo_empty = (count == '0);
  assign fifo_go    = ~wb_go & ~fifo_empty;
  assign head_reg   = q_reg[rd_ptr];
  assign head_data  = q_data[rd_ptr];

  // Ready depends only on current occupancy, so a full FIFO never accepts even while popping.
  assign bus.mc_ready = (count < CNT_FULL) & rst;
  assign push         = bus.mc_valid & bus.mc_ready;

  assign bus.hazard = ((bus.rs != 5'd0) & busy[bus.rs]) |
                      ((bus.rt != 5'd0) & busy[bus.rt]);

  assign bus.stall_req = stall_q;
  assign bus.rf_we     = we_q;
  assign bus.rf_wreg   = wreg_q;
  assign bus.rf_wdata  = wdata_q;

  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= bus.mc_reg;
      q_data[wr_ptr] <= bus.mc_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_go) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, fifo_go})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered write port; an r0 FIFO head is consumed without a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else if (wb_go) begin
      we_q    <= 1'b1;
      wreg_q  <= bus.wb_reg;
      wdata_q <= bus.wb_data;
    end else if (fifo_go && (head_reg != 5'd0)) begin
      we_q    <= 1'b1;
      wreg_q  <= head_reg;
      wdata_q <= head_data;
    end else begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end
  end

  // Starvation: count denied cycles while results wait; stall_req latches once saturated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (fifo_empty || fifo_go) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (starve_cnt != ST_MAX) starve_cnt <= starve_cnt + ST_ONE;
      if (starve_cnt == ST_MAX) stall_q <= 1'b1;
    end
  end

  // Clear before set so a same-cycle reissue of the retiring register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (fifo_go) busy_nxt[head_reg] = 1'b0;
    if (bus.iss_valid && (bus.iss_reg != 5'd0)) busy_nxt[bus.iss_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

  localparam int DEPTH = 2;

  typedef struct {
    int          cyc;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  wr_t         expq[$];
  wr_t         mcq[$];
  logic [31:0] m_busy = '0;

  rf_wport_arbiter_if bus();

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write-port monitor: every post-reset cycle the write enable must match the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        wr_t e;
        e = expq.pop_front();
        chk("rf_we", bus.rf_we, 1);
        chk("rf_wreg", bus.rf_wreg, e.r);
        chk("rf_wdata", bus.rf_wdata, e.d);
      end else begin
        chk("rf_we_idle", bus.rf_we, 0);
      end
    end
  end

  // One clock of stimulus; expectations are pushed as the inputs are driven.
  task automatic cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic iv, input logic [4:0] ir,
                       input logic [4:0] s, input logic [4:0] t);
    logic rdy;
    wr_t  e;
    bus.wb_valid = wv; bus.wb_reg = wr; bus.wb_data = wd;
    bus.mc_valid = mv; bus.mc_reg = mr; bus.mc_data = md;
    bus.iss_valid = iv; bus.iss_reg = ir;
    bus.rs = s; bus.rt = t;
    #1;
    rdy = (mcq.size() < DEPTH);
    chk("mc_ready", bus.mc_ready, rdy);
    chk("hazard", bus.hazard, (s != 0 && m_busy[s]) || (t != 0 && m_busy[t]));
    if (wv && wr != 0) begin
      expq.push_back('{cyc + 1, wr, wd});
    end else if (mcq.size() > 0) begin
      e = mcq.pop_front();
      if (e.r != 0) expq.push_back('{cyc + 1, e.r, e.d});
      m_busy[e.r] = 1'b0;
    end
    if (iv && ir != 0) m_busy[ir] = 1'b1;
    if (mv && rdy) mcq.push_back('{0, mr, md});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input logic [4:0] s, input logic [4:0] t);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, s, t);
  endtask

  initial begin
    bus.wb_valid = 0; bus.wb_reg = 0; bus.wb_data = 0;
    bus.mc_valid = 0; bus.mc_reg = 0; bus.mc_data = 0;
    bus.iss_valid = 0; bus.iss_reg = 0; bus.rs = 0; bus.rt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_rf_wreg", bus.rf_wreg, 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_stall_req", bus.stall_req, 0);
    chk("rst_mc_ready", bus.mc_ready, 0);
    chk("rst_hazard", bus.hazard, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single WB write, visible for exactly one cycle
    cycle(1, 3, 32'h0000_000A, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Multi-cycle result into an idle port: written two cycles after push
    cycle(0, 0, 0, 1, 6, 32'h55, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    idle(0, 0);

    // WB hogs the port while two results queue up
    for (int k = 0; k < 8; k++) begin
      if (k == 3) chk("stall_early", bus.stall_req, 0);
      if (k == 7) chk("stall_starved", bus.stall_req, 1);
      cycle(1, 5'(k + 1), 32'h1000 + k, (k < 2), 5'(10 + k), 32'h100 + k, 0, 0, 0, 0);
    end
    idle(0, 0);
    chk("stall_released", bus.stall_req, 0);
    cycle(1, 20, 32'h2000, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_restart", bus.stall_req, 0);
    idle(0, 0);
    idle(0, 0);

    // Scoreboard: issue reg 5, hazard next cycle, cleared after its result is granted
    cycle(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    idle(5, 0);
    cycle(1, 1, 32'h3000, 1, 5, 32'h5, 0, 0, 5, 0);
    idle(5, 0);
    idle(5, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 8, 0, 8);
    idle(0, 8);
    cycle(1, 2, 32'h3100, 1, 8, 32'h8, 0, 0, 0, 8);
    idle(0, 8);
    idle(0, 8);

    // Same-cycle set and clear of reg 7: set wins
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cycle(1, 4, 32'h4000, 1, 7, 32'h77, 0, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    cycle(1, 4, 32'h4001, 1, 7, 32'h78, 0, 0, 7, 0);
    idle(7, 0);
    idle(7, 0);

    // Register 0 is never written; a WB r0 slot is usable by the FIFO
    cycle(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    cycle(0, 0, 0, 1, 13, 32'hD0D0, 0, 0, 0, 0);
    cycle(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // Reset with two queued results and reg 9 busy
    cycle(1, 1, 32'h5000, 1, 12, 32'hC, 1, 9, 9, 0);
    cycle(1, 2, 32'h5001, 1, 14, 32'hE, 0, 0, 9, 0);
    chk("pre_rst_hazard", bus.hazard, 1);
    bus.wb_valid = 0; bus.mc_valid = 0; bus.iss_valid = 0;
    bus.rs = 9; bus.rt = 0;
    rst = 1'b0;
    #1;
    chk("arst_mc_ready", bus.mc_ready, 0);
    chk("arst_hazard", bus.hazard, 0);
    chk("arst_rf_we", bus.rf_we, 0);
    chk("arst_rf_wreg", bus.rf_wreg, 0);
    chk("arst_stall_req", bus.stall_req, 0);
    mcq.delete();
    expq.delete();
    m_busy = '0;
    @(posedge clk);
    cyc++;
    #1 rst = 1'b1;
    repeat (4) idle(9, 0);

    chk("pending_writes", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
